// File: rtl/lvds_link_train_ctrl.sv
// LVDS link training controller: aligns the receiver with bit-slip pulses
// against a fixed training word, then passes user payload once the link is up.
//
// state  | meaning
// IDLE   | waiting for PLL and receiver lock
// SETTLE | letting the receiver settle after entry or after a slip
// CHECK  | counting consecutive training-word matches
// SLIP   | one-cycle bit-slip request to the receiver
// LINKED | link up, user payload flows both ways
// FAIL   | slip budget exhausted, held until retrain or reset
module lvds_link_train_ctrl #(
  parameter logic [7:0] TRAIN_PAT  = 8'hA5,
  parameter int         SETTLE_CYC = 4,
  parameter int         MATCH_CNT  = 8,
  parameter int         MAX_SLIPS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       rx_locked,
  input  logic [7:0] rx_word,
  output logic [7:0] tx_word,
  output logic       rx_data_align,
  input  logic [7:0] user_tx_data,
  input  logic       user_tx_valid,
  output logic       user_tx_ready,
  output logic [7:0] user_rx_data,
  output logic       user_rx_valid,
  input  logic       retrain,
  output logic       link_up,
  output logic       link_fail,
  output logic [4:0] slip_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LINKED,
    FAIL
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CNT - 1);
  localparam logic [4:0] SLIP_MAX    = 5'(MAX_SLIPS);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [7:0] match_cnt;
  logic       locks_ok;

  assign locks_ok = pll_locked && rx_locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tx_word       <= TRAIN_PAT;
      rx_data_align <= 1'b0;
      user_tx_ready <= 1'b0;
      user_rx_data  <= 8'h00;
      user_rx_valid <= 1'b0;
      link_up       <= 1'b0;
      link_fail     <= 1'b0;
      slip_cnt      <= 5'd0;
      settle_cnt    <= 8'd0;
      match_cnt     <= 8'd0;
    end else if (state != IDLE && (retrain || !locks_ok)) begin
      // Retrain and lock loss share the same abort path back to IDLE.
      state         <= IDLE;
      tx_word       <= TRAIN_PAT;
      rx_data_align <= 1'b0;
      user_tx_ready <= 1'b0;
      user_rx_valid <= 1'b0;
      link_up       <= 1'b0;
      link_fail     <= 1'b0;
      slip_cnt      <= 5'd0;
      settle_cnt    <= 8'd0;
      match_cnt     <= 8'd0;
    end else begin
      rx_data_align <= 1'b0;
      case (state)
        IDLE: begin
          if (locks_ok) begin
            state      <= SETTLE;
            settle_cnt <= 8'd0;
            slip_cnt   <= 5'd0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= CHECK;
            settle_cnt <= 8'd0;
            match_cnt  <= 8'd0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        CHECK: begin
          if (rx_word == TRAIN_PAT) begin
            if (match_cnt == MATCH_LAST) begin
              state         <= LINKED;
              link_up       <= 1'b1;
              user_tx_ready <= 1'b1;
              match_cnt     <= 8'd0;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end else begin
            match_cnt <= 8'd0;
            if (slip_cnt < SLIP_MAX) begin
              state         <= SLIP;
              rx_data_align <= 1'b1;
              slip_cnt      <= (slip_cnt == SLIP_MAX) ? slip_cnt : slip_cnt + 5'd1;
            end else begin
              state     <= FAIL;
              link_fail <= 1'b1;
            end
          end
        end
        SLIP: begin
          state      <= SETTLE;
          settle_cnt <= 8'd0;
        end
        LINKED: begin
          tx_word       <= (user_tx_valid && user_tx_ready) ? user_tx_data : TRAIN_PAT;
          user_rx_data  <= rx_word;
          user_rx_valid <= 1'b1;
        end
        FAIL: begin
          state <= FAIL;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_link_train_ctrl.sv
// Directed bench for lvds_link_train_ctrl: loopback link-up, slip recovery,
// slip exhaustion, payload flow, lock loss and reset during a slip.
module tb_lvds_link_train_ctrl;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       rx_locked;
  logic [7:0] rx_word;
  logic [7:0] tx_word;
  logic       rx_data_align;
  logic [7:0] user_tx_data;
  logic       user_tx_valid;
  logic       user_tx_ready;
  logic [7:0] user_rx_data;
  logic       user_rx_valid;
  logic       retrain;
  logic       link_up;
  logic       link_fail;
  logic [4:0] slip_cnt;

  int checks = 0;
  int errors = 0;

  // 0: loopback, 1: loopback rotated until three slips seen, 2: stuck at zero
  int rx_mode = 0;
  int pulses = 0;
  int wide = 0;
  int cyc = 0;
  int last_pulse = -1;
  int min_gap = 1000;
  logic prev_align = 1'b0;

  lvds_link_train_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .rx_locked     (rx_locked),
    .rx_word       (rx_word),
    .tx_word       (tx_word),
    .rx_data_align (rx_data_align),
    .user_tx_data  (user_tx_data),
    .user_tx_valid (user_tx_valid),
    .user_tx_ready (user_tx_ready),
    .user_rx_data  (user_rx_data),
    .user_rx_valid (user_rx_valid),
    .retrain       (retrain),
    .link_up       (link_up),
    .link_fail     (link_fail),
    .slip_cnt      (slip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  always_comb begin
    rx_word = tx_word;
    case (rx_mode)
      1:       rx_word = rotl(tx_word, (pulses < 3) ? 3 - pulses : 0);
      2:       rx_word = 8'h00;
      default: rx_word = tx_word;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_data_align) begin
      pulses++;
      if (prev_align) wide++;
      if (last_pulse >= 0 && cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    prev_align = rx_data_align;
  endtask

  task automatic clear_stats();
    pulses = 0;
    wide = 0;
    last_pulse = -1;
    min_gap = 1000;
  endtask

  task automatic do_reset(input logic locks);
    rst = 1'b1;
    pll_locked = locks;
    rx_locked = locks;
    tick();
    tick();
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pll_locked = 1'b0;
    rx_locked = 1'b0;
    user_tx_data = 8'h00;
    user_tx_valid = 1'b0;
    retrain = 1'b0;

    // Reset values
    do_reset(1'b0);
    check("rst_tx_word", tx_word, 8'hA5);
    check("rst_align", rx_data_align, 0);
    check("rst_ready", user_tx_ready, 0);
    check("rst_rx_data", user_rx_data, 0);
    check("rst_rx_valid", user_rx_valid, 0);
    check("rst_link_up", link_up, 0);
    check("rst_link_fail", link_fail, 0);
    check("rst_slip_cnt", slip_cnt, 0);

    // No locks: stays idle even with retrain asserted
    retrain = 1'b1;
    repeat (3) tick();
    retrain = 1'b0;
    check("idle_no_lock", link_up, 0);

    // Loopback link-up after 1+4+8 edges
    pll_locked = 1'b1;
    rx_locked = 1'b1;
    repeat (12) tick();
    check("loop_before_up", link_up, 0);
    tick();
    check("loop_link_up", link_up, 1);
    check("loop_ready", user_tx_ready, 1);
    check("loop_valid_entry", user_rx_valid, 0);
    check("loop_slip_cnt", slip_cnt, 0);
    check("loop_no_pulse", pulses, 0);
    tick();
    check("loop_valid", user_rx_valid, 1);
    check("loop_rx_fill", user_rx_data, 8'hA5);

    // Payload through loopback
    user_tx_valid = 1'b1;
    user_tx_data = 8'h01;
    tick();
    check("pl_tx0", tx_word, 8'h01);
    user_tx_data = 8'h11;
    tick();
    check("pl_tx1", tx_word, 8'h11);
    check("pl_rx0", user_rx_data, 8'h01);
    user_tx_data = 8'h22;
    tick();
    check("pl_tx2", tx_word, 8'h22);
    check("pl_rx1", user_rx_data, 8'h11);
    user_tx_valid = 1'b0;
    tick();
    check("pl_tx_fill", tx_word, 8'hA5);
    check("pl_rx2", user_rx_data, 8'h22);
    check("pl_valid_held", user_rx_valid, 1);

    // Receiver lock loss while linked, then relink
    rx_locked = 1'b0;
    tick();
    check("ll_link_up", link_up, 0);
    check("ll_ready", user_tx_ready, 0);
    check("ll_valid", user_rx_valid, 0);
    rx_locked = 1'b1;
    repeat (12) tick();
    check("ll_relink_early", link_up, 0);
    tick();
    check("ll_relink", link_up, 1);

    // Rotated receive word needs three slips
    rx_mode = 1;
    do_reset(1'b1);
    n = 0;
    while (!link_up && n < 300) begin
      tick();
      n++;
    end
    check("rot_timeout", n < 300, 1);
    check("rot_pulses", pulses, 3);
    check("rot_single_cycle", wide, 0);
    check("rot_gap_min", min_gap >= 5, 1);
    check("rot_slip_cnt", slip_cnt, 3);
    check("rot_link_up", link_up, 1);

    // Stuck receive word exhausts the slip budget
    rx_mode = 2;
    do_reset(1'b1);
    n = 0;
    while (!link_fail && n < 400) begin
      tick();
      n++;
    end
    check("stk_timeout", n < 400, 1);
    check("stk_pulses", pulses, 16);
    check("stk_slip_cnt", slip_cnt, 16);
    check("stk_link_up", link_up, 0);
    repeat (5) tick();
    check("stk_fail_held", link_fail, 1);
    check("stk_saturate", slip_cnt, 16);
    check("stk_no_more", pulses, 16);
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    check("rt_link_fail", link_fail, 0);
    check("rt_slip_cnt", slip_cnt, 0);

    // Reset landing on a slip cycle
    do_reset(1'b1);
    n = 0;
    while (!rx_data_align && n < 50) begin
      tick();
      n++;
    end
    check("sr_timeout", n < 50, 1);
    rst = 1'b1;
    tick();
    check("sr_align", rx_data_align, 0);
    check("sr_slip_cnt", slip_cnt, 0);
    check("sr_tx_word", tx_word, 8'hA5);
    check("sr_link_fail", link_fail, 0);
    rst = 1'b0;
    pll_locked = 1'b0;
    tick();
    check("sr_align_after", rx_data_align, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
